// File: rtl/fetch_pkg.sv
// Shared types for the Otter fetch stage: next-PC source select and the queued fetch entry.
// The entry carries the instruction with its PC and PC+4 so decode never recomputes them.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_NONE   = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_src_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage, zero when empty.
// Push/pop same cycle allowed; pop on empty is ignored; flush wins over push and pop.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   vld,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign vld     = (count != '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && vld && !flush;
  assign dout    = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Otter fetch stage: owns the PC, keeps up to DEPTH fetches in flight, queues responses for decode.
// Response to DEC_VALID is 1 cycle; requests stop when queue + in-flight + to-drop reaches DEPTH.
module fetch_queue_stage #(
  parameter int              XLEN         = fetch_pkg::XLEN,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
  input  logic            IF_CLK,
  input  logic            IF_RST_N,
  input  logic [1:0]      PC_SOURCE,
  input  logic [XLEN-1:0] JALR,
  input  logic [XLEN-1:0] BRANCH,
  input  logic [XLEN-1:0] JAL,
  output logic            MEM_REQ,
  output logic [XLEN-1:0] MEM_ADDR,
  input  logic            MEM_GNT,
  input  logic            MEM_RVALID,
  input  logic [31:0]     MEM_RDATA,
  output logic            DEC_VALID,
  input  logic            DEC_READY,
  output logic [31:0]     DEC_INSTR,
  output logic [XLEN-1:0] DEC_PC,
  output logic [XLEN-1:0] DEC_PC_PLUS_FOUR
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     credit_used;
  logic            redirect;
  logic            grant;
  logic            keep_resp;
  logic            pop;
  logic            head_vld;
  pc_src_e         src;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign src      = pc_src_e'(PC_SOURCE);
  assign redirect = (src != PC_NONE);

  always_comb begin
    target = pc;
    case (src)
      PC_JALR:   target = JALR;
      PC_BRANCH: target = BRANCH;
      PC_JAL:    target = JAL;
      default:   target = pc;
    endcase
    target[1:0] = 2'b00;
  end

  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding} + {1'b0, drop_cnt};
  assign MEM_REQ     = IF_RST_N && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign MEM_ADDR    = pc;
  assign grant       = MEM_REQ && MEM_GNT;
  assign keep_resp   = MEM_RVALID && !redirect && (drop_cnt == '0);

  // Live in-flight fetches are contiguous (a redirect zeroes them), so the
  // oldest one sits outstanding words behind the fetch PC.
  assign resp_pc = pc - (XLEN'(outstanding) << 2);

  always_comb begin
    push_entry              = '0;
    push_entry.instr        = MEM_RDATA;
    push_entry.pc           = resp_pc;
    push_entry.pc_plus_four = resp_pc + XLEN'(4);
  end

  assign DEC_VALID        = head_vld && !redirect;
  assign pop              = DEC_VALID && DEC_READY;
  assign DEC_INSTR        = head.instr;
  assign DEC_PC           = head.pc;
  assign DEC_PC_PLUS_FOUR = head.pc_plus_four;

  always_ff @(posedge IF_CLK or negedge IF_RST_N) begin
    if (!IF_RST_N) begin
      pc          <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect) begin
      // A response this cycle retires against the old drop_cnt or outstanding;
      // either way the net effect is one fewer to drop.
      pc          <= target;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding + CW'(MEM_GNT) - CW'(MEM_RVALID);
    end else begin
      if (grant) pc <= pc + XLEN'(4);
      outstanding <= outstanding + CW'(grant) - CW'(keep_resp);
      if (MEM_RVALID && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (IF_CLK),
    .rst_n (IF_RST_N),
    .flush (redirect),
    .push  (keep_resp),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .vld   (head_vld),
    .count (occupancy)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: one instance from reset vector 0 with a queued memory model,
// one from reset vector FFFF_FFF8 driven by hand for wraparound and mid-stream reset.
module tb_fetch_queue_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_source;
  logic [31:0] jalr, branch, jal;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus_four;

  logic        b_rst_n;
  logic        b_mem_req, b_mem_gnt, b_mem_rvalid;
  logic [31:0] b_mem_addr, b_mem_rdata;
  logic        b_dec_valid, b_dec_ready;
  logic [31:0] b_dec_instr, b_dec_pc, b_dec_pc_plus_four;

  int          vectors;
  int          miscompares;
  int          grants;
  logic        mem_stall;
  logic [31:0] pend[$];
  logic [31:0] e;

  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut_a (
    .IF_CLK(clk), .IF_RST_N(rst_n), .PC_SOURCE(pc_source),
    .JALR(jalr), .BRANCH(branch), .JAL(jal),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_GNT(mem_gnt),
    .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata),
    .DEC_VALID(dec_valid), .DEC_READY(dec_ready), .DEC_INSTR(dec_instr),
    .DEC_PC(dec_pc), .DEC_PC_PLUS_FOUR(dec_pc_plus_four)
  );

  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8)) dut_b (
    .IF_CLK(clk), .IF_RST_N(b_rst_n), .PC_SOURCE(2'b00),
    .JALR(32'h0), .BRANCH(32'h0), .JAL(32'h0),
    .MEM_REQ(b_mem_req), .MEM_ADDR(b_mem_addr), .MEM_GNT(b_mem_gnt),
    .MEM_RVALID(b_mem_rvalid), .MEM_RDATA(b_mem_rdata),
    .DEC_VALID(b_dec_valid), .DEC_READY(b_dec_ready), .DEC_INSTR(b_dec_instr),
    .DEC_PC(b_dec_pc), .DEC_PC_PLUS_FOUR(b_dec_pc_plus_four)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // In-order memory: answers every accepted grant (and a grant in a redirect
  // cycle) one cycle later, unless mem_stall holds the responses back.
  task automatic step();
    logic g;
    g = mem_gnt && (mem_req || (pc_source != 2'b00));
    if (mem_req && mem_gnt) grants++;
    if (g) pend.push_back(mem_addr);
    @(posedge clk);
    #1;
    if (!mem_stall && pend.size() != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ~pend.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0; grants = 0; mem_stall = 1'b0;
    rst_n = 1'b0; b_rst_n = 1'b0;
    pc_source = 2'b00; jalr = 32'h0; branch = 32'h0; jal = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; dec_ready = 1'b0;
    b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = 32'h0; b_dec_ready = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_pc4", dec_pc_plus_four, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_b_req", b_mem_req, 1'b0);
    chk("rst_b_addr", b_mem_addr, 32'hFFFF_FFF8);

    // Streaming with a 1-cycle memory and decode always ready
    @(negedge clk);
    rst_n = 1'b1; mem_gnt = 1'b1; dec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t1_addr", mem_addr, 32'(4 * k));
      if (k >= 2) begin
        e = 32'(4 * (k - 2));
        chk("t1_dec_valid", dec_valid, 1'b1);
        chk("t1_dec_pc", dec_pc, e);
        chk("t1_dec_pc4", dec_pc_plus_four, e + 32'd4);
        chk("t1_dec_instr", dec_instr, ~e);
      end
      step();
    end
    mem_gnt = 1'b0;
    repeat (4) step();
    #1;
    chk("t1_drained", dec_valid, 1'b0);
    chk("t1_pc", mem_addr, 32'd20);

    // Decode stalled: credit limit stops requests after DEPTH grants
    grants = 0; dec_ready = 1'b0; mem_gnt = 1'b1;
    repeat (6) step();
    #1;
    chk("t2_grants", 32'(grants), 32'd4);
    chk("t2_req_full", mem_req, 1'b0);
    chk("t2_head", dec_pc, 32'd20);
    dec_ready = 1'b1;
    #1;
    chk("t2_req_b0", mem_req, 1'b0);
    step(); #1;
    chk("t2_pop1", dec_pc, 32'd24);
    chk("t2_req_resume", mem_req, 1'b1);
    chk("t2_addr_resume", mem_addr, 32'd36);
    step(); #1;
    chk("t2_pop2", dec_pc, 32'd28);
    step(); #1;
    chk("t2_pop3", dec_pc, 32'd32);
    mem_gnt = 1'b0;
    repeat (8) step();
    #1;
    chk("t2_drained", dec_valid, 1'b0);

    // Request hold without grant, after a JAL redirect to 8
    pc_source = 2'b11; jal = 32'h0000_000B;
    #1;
    chk("t3_req_redirect", mem_req, 1'b0);
    step();
    pc_source = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_req", mem_req, 1'b1);
      chk("t3_hold_addr", mem_addr, 32'd8);
      step();
    end
    mem_gnt = 1'b1;
    #1;
    chk("t3_grant_addr", mem_addr, 32'd8);
    step();
    mem_gnt = 1'b0;
    #1;
    chk("t3_advance", mem_addr, 32'd12);
    step(); #1;
    chk("t3_dec_pc", dec_pc, 32'd8);
    step();

    // Branch redirect with three fetches in flight
    mem_stall = 1'b1; mem_gnt = 1'b1;
    repeat (3) step();
    pc_source = 2'b10; branch = 32'h100; mem_gnt = 1'b0;
    #1;
    chk("t4_req_redirect", mem_req, 1'b0);
    step();
    pc_source = 2'b00; mem_stall = 1'b0; mem_gnt = 1'b1;
    #1;
    chk("t4_req", mem_req, 1'b1);
    chk("t4_addr", mem_addr, 32'h100);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_dropped", dec_valid, 1'b0);
      step();
    end
    #1;
    chk("t4_first_valid", dec_valid, 1'b1);
    chk("t4_first_pc", dec_pc, 32'h100);
    chk("t4_first_instr", dec_instr, ~32'h100);
    step();
    mem_gnt = 1'b0;
    repeat (8) step();
    #1;
    chk("t4_drained", dec_valid, 1'b0);
    chk("t4_pc", mem_addr, 32'h110);

    // JALR redirect in the same cycle as a grant and a response
    mem_gnt = 1'b1;
    step();
    pc_source = 2'b01; jalr = 32'h203;
    #1;
    chk("t5_req_redirect", mem_req, 1'b0);
    step();
    pc_source = 2'b00;
    #1;
    chk("t5_req", mem_req, 1'b1);
    chk("t5_addr", mem_addr, 32'h200);
    chk("t5_valid_e2", dec_valid, 1'b0);
    step(); #1;
    chk("t5_valid_e3", dec_valid, 1'b0);
    step(); #1;
    chk("t5_valid_e4", dec_valid, 1'b1);
    chk("t5_pc", dec_pc, 32'h200);
    chk("t5_instr", dec_instr, ~32'h200);
    step();
    pc_source = 2'b11; jal = 32'h40;
    #1;
    chk("t5_valid_forced0", dec_valid, 1'b0);
    step();
    pc_source = 2'b00;
    #1;
    chk("t5_flushed", dec_valid, 1'b0);
    chk("t5_jal_addr", mem_addr, 32'h40);
    step(); #1;
    chk("t5_stale_dropped", dec_valid, 1'b0);
    step(); #1;
    chk("t5_jal_valid", dec_valid, 1'b1);
    chk("t5_jal_pc", dec_pc, 32'h40);
    mem_gnt = 1'b0;
    repeat (4) step();

    // Wraparound from reset vector FFFF_FFF8, then reset mid-stream
    b_rst_n = 1'b1; b_mem_gnt = 1'b1; b_dec_ready = 1'b1;
    #1;
    chk("tb_req", b_mem_req, 1'b1);
    chk("tb_addr0", b_mem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    b_mem_rvalid = 1'b1; b_mem_rdata = 32'h0000_0013;
    #1;
    chk("tb_addr1", b_mem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    b_mem_rdata = 32'h0000_0017;
    #1;
    chk("tb_addr2", b_mem_addr, 32'h0000_0000);
    chk("tb_valid", b_dec_valid, 1'b1);
    chk("tb_pc0", b_dec_pc, 32'hFFFF_FFF8);
    chk("tb_pc4_0", b_dec_pc_plus_four, 32'hFFFF_FFFC);
    chk("tb_instr0", b_dec_instr, 32'h0000_0013);
    @(negedge clk);
    b_mem_rvalid = 1'b0;
    #1;
    chk("tb_pc1", b_dec_pc, 32'hFFFF_FFFC);
    chk("tb_pc4_wrap", b_dec_pc_plus_four, 32'h0000_0000);
    chk("tb_instr1", b_dec_instr, 32'h0000_0017);
    b_rst_n = 1'b0;
    #1;
    chk("tb_rst_valid", b_dec_valid, 1'b0);
    chk("tb_rst_req", b_mem_req, 1'b0);
    chk("tb_rst_pc", b_dec_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised instruction-fetch stage for the Otter pipeline. It owns the PC and the next-PC select, and keeps up to DEPTH fetches in flight to a handshaked instruction memory. Returned instructions are buffered in a DEPTH-entry queue and handed to decode with a valid/ready handshake. A redirect (JALR/BRANCH/JAL) flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, width of PC, targets and addresses
DEPTH, 4, queue entries and maximum outstanding fetches (power of 2, >= 2)
RESET_VECTOR, 32'h0000_0000, PC value after reset

Ports:
IF_CLK  in  1  clock, rising edge
IF_RST_N  in  1  reset, asynchronous, active-low
PC_SOURCE  in  2  00 no redirect, 01 JALR, 10 BRANCH, 11 JAL; non-zero means redirect this cycle
JALR  in  XLEN  JALR target
BRANCH  in  XLEN  branch target
JAL  in  XLEN  JAL target
MEM_REQ  out  1  fetch request valid
MEM_ADDR  out  XLEN  fetch address, equals fetch PC
MEM_GNT  in  1  request accepted this cycle
MEM_RVALID  in  1  response valid; responses return in request order, one per grant
MEM_RDATA  in  32  response instruction
DEC_VALID  out  1  queue head valid to decode
DEC_READY  in  1  decode accepts head
DEC_INSTR  out  32  head instruction
DEC_PC  out  XLEN  head PC
DEC_PC_PLUS_FOUR  out  XLEN  head PC + 4

Behaviour:
- Reset (async assert, sync release): fetch PC = RESET_VECTOR; queue empty; outstanding = 0; drop_cnt = 0. MEM_REQ = 0, DEC_VALID = 0, and DEC_INSTR/DEC_PC/DEC_PC_PLUS_FOUR = 0. Reset mid-operation abandons everything; responses arriving after release that belong to pre-reset grants are not tracked, so the memory must also be reset.
- Credit rule: MEM_REQ = 1 when occupancy + outstanding + drop_cnt < DEPTH and no redirect this cycle. MEM_REQ is combinational from state and PC_SOURCE.
- Request hold: while MEM_REQ = 1 and MEM_GNT = 0, MEM_ADDR is held stable. The only exception is a redirect, which withdraws the request.
- Grant (MEM_REQ & MEM_GNT): outstanding += 1 and fetch PC += 4, wrapping mod 2^XLEN. The entry records PC and PC + 4, also wrapping.
- Response with drop_cnt = 0: enqueue {MEM_RDATA, PC, PC+4} and decrement outstanding. The credit rule guarantees space.
- Response with drop_cnt > 0: discard it and decrement drop_cnt.
- Dequeue: DEC_VALID & DEC_READY pops the head. The queue outputs are registered, with zero bubble on back-to-back pops. Fetch PC to DEC_VALID latency is 1 cycle after MEM_RVALID (2 cycles minimum from grant with a 1-cycle memory).
- Simultaneous enqueue and dequeue are allowed when full or empty. Occupancy is unchanged, and on an empty queue the new entry appears the next cycle.
- Redirect (PC_SOURCE != 00):
  - Next fetch PC = selected target with bits [1:0] cleared.
  - Queue is cleared and DEC_VALID is forced 0 that cycle, so no pop occurs.
  - drop_cnt += outstanding + (MEM_GNT this cycle), and outstanding = 0.
  - A response arriving in the redirect cycle is discarded and counts against the old drop_cnt/outstanding.
  - MEM_REQ = 0 in the redirect cycle; fetching resumes the next cycle.
- Back-to-back redirects: the last one wins, and drop_cnt accumulates.
- Counters are $clog2(DEPTH)+1 bits wide; they never overflow because of the credit rule.

Decomposition:
- Package fetch_pkg:
  - pc_src_e enum (PC_NONE, PC_JALR, PC_BRANCH, PC_JAL)
  - fetch_entry_t struct {instr, pc, pc_plus_four}, parametrised via XLEN localparam
  - RESET_VECTOR default
- One sub-module: fetch_fifo (synchronous FIFO with flush, parametrised on DEPTH and entry type).

Test Plan:
- Reset, MEM_GNT = 1, 1-cycle memory, DEC_READY = 1 -> MEM_ADDR 0,4,8,…; DEC_PC 0,4,8 on consecutive cycles; DEC_PC_PLUS_FOUR = DEC_PC + 4.
- DEC_READY = 0, DEPTH = 4 -> exactly 4 grants, then MEM_REQ = 0; raise DEC_READY -> 4 pops in order, and requests resume.
- MEM_GNT = 0 for 3 cycles with MEM_REQ high -> MEM_ADDR stable at 8; grant -> PC advances to 12.
- 3 fetches outstanding, PC_SOURCE = 10, BRANCH = 32'h100 -> next 3 responses discarded; first DEC_PC = 32'h100.
- Redirect with JALR = 32'h203 in the same cycle as a grant and a response -> drop_cnt covers the granted request; next MEM_ADDR = 32'h200.
- RESET_VECTOR = 32'hFFFF_FFF8, run 3 fetches -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; assert IF_RST_N low mid-stream -> DEC_VALID = 0 and MEM_REQ = 0 immediately.
